// File: rtl/signal_pwm_pkg.sv
// Shared types and constants for the PWM output stage behind the signaloutput slave.
package signal_pwm_pkg;

  localparam int CNT_W_DEF  = 16;
  localparam int DEAD_W_DEF = 8;

  // Bit positions inside the slave's control register (slv_reg2)
  localparam int ENABLE_BIT = 0;
  localparam int DIR_BIT    = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/signal_pwm_stage.sv
// Register-to-pin PWM stage: double-buffered period/duty, dead-time on direction
// reversal, and a completed-period counter for read-back.
module signal_pwm_stage
  import signal_pwm_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DEAD_W = DEAD_W_DEF
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_duty,
  input  logic              cfg_enable,
  input  logic              cfg_dir,
  input  logic [DEAD_W-1:0] cfg_dead,
  output logic              pwm_out,
  output logic              dir_out,
  output logic              period_tick,
  output logic              in_deadtime,
  output logic [31:0]       period_count
);

  pwm_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  per_sh_q;
  logic [CNT_W-1:0]  duty_sh_q;
  logic [DEAD_W-1:0] dead_cnt_q;
  logic              pwm_q;
  logic              dir_q;
  logic              tick_q;
  logic              in_dead_q;
  logic [31:0]       period_count_q;

  logic [CNT_W-1:0]  cnt_d;
  logic [DEAD_W-1:0] dead_cnt_d;
  logic [31:0]       period_count_d;
  logic              wrap_d;
  logic              duty_hit_d;

  assign cnt_d          = cnt_q + CNT_W'(1);
  assign dead_cnt_d     = dead_cnt_q - DEAD_W'(1);
  assign period_count_d = period_count_q + 32'd1;
  assign wrap_d         = (cnt_q == per_sh_q);
  // Duty larger than the period never fails the compare, giving 100 %
  assign duty_hit_d     = (cnt_q < duty_sh_q);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      per_sh_q       <= '0;
      duty_sh_q      <= '0;
      dead_cnt_q     <= '0;
      pwm_q          <= 1'b0;
      dir_q          <= 1'b0;
      tick_q         <= 1'b0;
      in_dead_q      <= 1'b0;
      period_count_q <= '0;
    end else begin
      tick_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q     <= '0;
          pwm_q     <= 1'b0;
          in_dead_q <= 1'b0;
          if (cfg_enable) begin
            per_sh_q  <= cfg_period;
            duty_sh_q <= cfg_duty;
            dir_q     <= cfg_dir;
            state_q   <= RUN;
          end
        end

        RUN: begin
          // The wrap is counted even when a disable arrives on the same edge
          if (wrap_d) begin
            tick_q         <= 1'b1;
            period_count_q <= period_count_d;
          end
          if (!cfg_enable) begin
            state_q <= IDLE;
            pwm_q   <= 1'b0;
            cnt_q   <= '0;
          end else if (wrap_d) begin
            cnt_q     <= '0;
            per_sh_q  <= cfg_period;
            duty_sh_q <= cfg_duty;
            if (cfg_dir != dir_q) begin
              dead_cnt_q <= cfg_dead;
              pwm_q      <= 1'b0;
              in_dead_q  <= 1'b1;
              state_q    <= DEAD;
            end else begin
              pwm_q <= duty_hit_d;
            end
          end else begin
            cnt_q <= cnt_d;
            pwm_q <= duty_hit_d;
          end
        end

        DEAD: begin
          pwm_q <= 1'b0;
          if (!cfg_enable) begin
            in_dead_q <= 1'b0;
            state_q   <= IDLE;
          end else if (dead_cnt_q == '0) begin
            // pwm_q stays low here so the output cannot move with dir_out
            dir_q     <= cfg_dir;
            per_sh_q  <= cfg_period;
            duty_sh_q <= cfg_duty;
            cnt_q     <= '0;
            in_dead_q <= 1'b0;
            state_q   <= RUN;
          end else begin
            dead_cnt_q <= dead_cnt_d;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign pwm_out      = pwm_q;
  assign dir_out      = dir_q;
  assign period_tick  = tick_q;
  assign in_deadtime  = in_dead_q;
  assign period_count = period_count_q;

endmodule

// File: tb/tb_signal_pwm_stage.sv
// Directed bench for signal_pwm_stage with P=9 (10-cycle periods) and T=4 dead-time.
module tb_signal_pwm_stage;

  localparam int CNT_W  = 16;
  localparam int DEAD_W = 8;

  logic              ACLK = 1'b0;
  logic              ARESETN = 1'b0;
  logic [CNT_W-1:0]  cfg_period = '0;
  logic [CNT_W-1:0]  cfg_duty = '0;
  logic              cfg_enable = 1'b0;
  logic              cfg_dir = 1'b0;
  logic [DEAD_W-1:0] cfg_dead = '0;
  logic              pwm_out;
  logic              dir_out;
  logic              period_tick;
  logic              in_deadtime;
  logic [31:0]       period_count;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_pc  = 0;

  signal_pwm_stage #(.CNT_W(CNT_W), .DEAD_W(DEAD_W)) dut (
    .ACLK         (ACLK),
    .ARESETN      (ARESETN),
    .cfg_period   (cfg_period),
    .cfg_duty     (cfg_duty),
    .cfg_enable   (cfg_enable),
    .cfg_dir      (cfg_dir),
    .cfg_dead     (cfg_dead),
    .pwm_out      (pwm_out),
    .dir_out      (dir_out),
    .period_tick  (period_tick),
    .in_deadtime  (in_deadtime),
    .period_count (period_count)
  );

  initial forever #5 ACLK = ~ACLK;

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " pwm"},   32'(pwm_out),     32'd0);
    chk({tag, " dir"},   32'(dir_out),     32'd0);
    chk({tag, " tick"},  32'(period_tick), 32'd0);
    chk({tag, " dead"},  32'(in_deadtime), 32'd0);
    chk({tag, " count"}, period_count,     32'd0);
  endtask

  // One full 10-cycle period starting just after a wrap (or RUN entry).
  // After edge j the output reflects cnt=j-1, so it is high while j-1 < d.
  // chg_j>0 writes new_d into cfg_duty after edge chg_j.
  task automatic run_period(input int d, input int chg_j, input logic [CNT_W-1:0] new_d);
    for (int j = 1; j <= 10; j++) begin
      step();
      chk($sformatf("pwm p%0d j%0d", exp_pc, j), 32'(pwm_out), 32'((j - 1) < d));
      chk($sformatf("tick p%0d j%0d", exp_pc, j), 32'(period_tick), 32'(j == 10));
      if (j == chg_j) cfg_duty = new_d;
    end
    exp_pc++;
    chk($sformatf("period_count p%0d", exp_pc), period_count, 32'(exp_pc));
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk_all_zero("reset");
    ARESETN    = 1'b1;
    cfg_period = 16'd9;
    cfg_duty   = 16'd3;
    cfg_dead   = 8'd4;
    cfg_dir    = 1'b0;
    step();
    chk_all_zero("idle");

    // Startup: RUN entry edge, then the first high cycle on the next edge
    cfg_enable = 1'b1;
    step();
    chk("entry pwm", 32'(pwm_out), 32'd0);
    run_period(3, 0, '0);
    run_period(3, 0, '0);

    // Mid-period duty change takes effect only on the next period
    run_period(3, 2, 16'd7);
    run_period(7, 0, '0);
    run_period(7, 5, 16'd0);
    run_period(0, 0, '0);
    run_period(0, 3, 16'd12);
    run_period(12, 0, '0);
    run_period(12, 2, 16'd3);

    // Direction reversal: period completes, then 5 dead cycles
    for (int j = 1; j <= 10; j++) begin
      step();
      if (j == 3) cfg_dir = 1'b1;
      chk($sformatf("rev pwm j%0d", j), 32'(pwm_out), 32'(j <= 3));
      chk($sformatf("rev dir j%0d", j), 32'(dir_out), 32'd0);
    end
    exp_pc++;
    chk("rev wrap tick", 32'(period_tick), 32'd1);
    chk("rev wrap count", period_count, 32'(exp_pc));
    chk("rev dead0", 32'(in_deadtime), 32'd1);
    chk("rev dead0 pwm", 32'(pwm_out), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("dead%0d flag", k), 32'(in_deadtime), 32'd1);
      chk($sformatf("dead%0d pwm", k), 32'(pwm_out), 32'd0);
      chk($sformatf("dead%0d dir", k), 32'(dir_out), 32'd0);
    end
    step();
    chk("dead exit flag", 32'(in_deadtime), 32'd0);
    chk("dead exit dir", 32'(dir_out), 32'd1);
    chk("dead exit pwm", 32'(pwm_out), 32'd0);
    run_period(3, 0, '0);

    // Second reversal, aborted by disable while in DEAD
    cfg_dir = 1'b0;
    run_period(3, 0, '0);
    chk("abort dead flag", 32'(in_deadtime), 32'd1);
    step();
    step();
    cfg_enable = 1'b0;
    step();
    chk("abort idle flag", 32'(in_deadtime), 32'd0);
    chk("abort idle pwm", 32'(pwm_out), 32'd0);
    chk("abort idle dir", 32'(dir_out), 32'd1);
    step();
    step();
    chk("idle hold dir", 32'(dir_out), 32'd1);
    chk("idle hold count", period_count, 32'(exp_pc));

    // Re-enable: direction taken at once, no dead phase
    cfg_enable = 1'b1;
    step();
    chk("reen dir", 32'(dir_out), 32'd0);
    chk("reen flag", 32'(in_deadtime), 32'd0);
    chk("reen pwm", 32'(pwm_out), 32'd0);
    run_period(3, 0, '0);

    // Disable coinciding with a wrap and a direction request: disable wins
    for (int j = 1; j <= 9; j++) step();
    cfg_enable = 1'b0;
    cfg_dir    = 1'b1;
    step();
    exp_pc++;
    chk("dis-wrap tick", 32'(period_tick), 32'd1);
    chk("dis-wrap count", period_count, 32'(exp_pc));
    chk("dis-wrap flag", 32'(in_deadtime), 32'd0);
    chk("dis-wrap pwm", 32'(pwm_out), 32'd0);
    chk("dis-wrap dir", 32'(dir_out), 32'd0);
    step();
    chk("dis-wrap after flag", 32'(in_deadtime), 32'd0);
    chk("dis-wrap after tick", 32'(period_tick), 32'd0);

    // Asynchronous reset mid-RUN
    cfg_enable = 1'b1;
    step();
    chk("run dir", 32'(dir_out), 32'd1);
    for (int j = 1; j <= 2; j++) step();
    chk("pre-reset pwm", 32'(pwm_out), 32'd1);
    ARESETN = 1'b0;
    #1;
    chk_all_zero("async reset");
    for (int j = 0; j < 3; j++) step();
    chk_all_zero("held reset");
    ARESETN = 1'b1;
    exp_pc  = 0;
    step();
    chk("restart entry pwm", 32'(pwm_out), 32'd0);
    chk("restart dir", 32'(dir_out), 32'd1);
    run_period(3, 0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
